// File: rtl/fireball_pkg.sv
// fireball_pkg: state encoding, direction codes and screen geometry shared by
// the fireball motion controller, sprite renderer and pixel mux.
package fireball_pkg;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FLY      = 2'd1;
  localparam logic [1:0] ST_EXPLODE  = 2'd2;
  localparam logic [1:0] ST_COOLDOWN = 2'd3;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam int FB_SCREEN_W = 96;
  localparam int FB_SCREEN_H = 64;
  localparam int FB_SIZE     = 8;
  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/tick_down_counter.sv
// tick_down_counter: loadable down-counter that saturates at zero, stepping
// once per enable pulse; load wins over enable.
module tick_down_counter #(
  parameter int W = 4
) (
  input  logic         CLOCK,
  input  logic         RESET_N,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;
  assign zero = count == '0;
  always_ff @(posedge CLOCK or negedge RESET_N)
    if (!RESET_N) count <= '0;
    else if (load) count <= load_val;
    else if (en && !zero) count <= count - W'(1);
endmodule

// File: rtl/fireball_motion.sv
// fireball_motion: launch/fly/explode/cooldown lifecycle of one fireball,
// producing its registered top-left position and visibility flags.
module fireball_motion
  import fireball_pkg::*;
#(
  parameter int SCREEN_W       = FB_SCREEN_W,
  parameter int SCREEN_H       = FB_SCREEN_H,
  parameter int SIZE           = FB_SIZE,
  parameter int SPEED          = 2,
  parameter int EXPLODE_TICKS  = 4,
  parameter int COOLDOWN_TICKS = 8
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       move_tick,
  input  logic       fire,
  input  logic       dir,
  input  logic [6:0] launch_x,
  input  logic [5:0] launch_y,
  input  logic       hit,
  output logic [6:0] leftX,
  output logic [5:0] topY,
  output logic       visible,
  output logic       exploding,
  output logic       ready,
  output logic       done
);
  localparam int CW = cnt_w(EXPLODE_TICKS, COOLDOWN_TICKS);
  localparam logic [6:0] MAX_X = 7'(SCREEN_W - SIZE);
  localparam logic [5:0] MAX_Y = 6'(SCREEN_H - SIZE);
  logic [1:0] state;
  logic heading, load, zero, exit_now;
  logic [CW-1:0] load_val;
  logic [7:0] right_next;
  assign visible   = state == ST_FLY || state == ST_EXPLODE;
  assign exploding = state == ST_EXPLODE;
  assign ready     = state == ST_IDLE;
  // 8-bit sum so a sprite near the right edge cannot wrap past 127
  assign right_next = {1'b0, leftX} + 8'(SPEED);
  assign exit_now   = heading == DIR_RIGHT ? right_next > {1'b0, MAX_X} : leftX < 7'(SPEED);
  // counters are loaded with ticks-1 so the final tick is seen with zero set
  always_comb begin
    load     = (state == ST_FLY && (hit || (move_tick && exit_now))) ||
               (state == ST_EXPLODE && move_tick && zero);
    load_val = state == ST_FLY && hit ? CW'(EXPLODE_TICKS - 1) : CW'(COOLDOWN_TICKS - 1);
  end
  tick_down_counter #(.W(CW)) dwell (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .load(load), .en(move_tick),
    .load_val(load_val), .zero(zero)
  );
  always_ff @(posedge CLOCK or negedge RESET_N)
    if (!RESET_N) begin
      state   <= ST_IDLE;
      heading <= DIR_LEFT;
      leftX   <= '0;
      topY    <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE:
          if (fire) begin
            state   <= ST_FLY;
            heading <= dir;
            leftX   <= launch_x > MAX_X ? MAX_X : launch_x;
            topY    <= launch_y > MAX_Y ? MAX_Y : launch_y;
          end
        ST_FLY:
          if (hit) begin
            state <= ST_EXPLODE;
            done  <= 1'b1;
          end else if (move_tick && exit_now) begin
            state <= ST_COOLDOWN;
            done  <= 1'b1;
          end else if (move_tick)
            leftX <= heading == DIR_RIGHT ? leftX + 7'(SPEED) : leftX - 7'(SPEED);
        ST_EXPLODE: if (move_tick && zero) state <= ST_COOLDOWN;
        default:    if (move_tick && zero) state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_fireball_motion.sv
// tb_fireball_motion: directed stimulus with a per-cycle behavioural model
// plus hand-computed literal checks at key points of each scenario.
module tb_fireball_motion;
  logic CLOCK = 0, RESET_N = 0, move_tick = 0, fire = 0, dir = 0, hit = 0;
  logic [6:0] launch_x = 0;
  logic [5:0] launch_y = 0;
  logic [6:0] leftX;
  logic [5:0] topY;
  logic visible, exploding, ready, done;
  int checks = 0, errors = 0;
  fireball_motion dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .move_tick(move_tick), .fire(fire), .dir(dir),
    .launch_x(launch_x), .launch_y(launch_y), .hit(hit), .leftX(leftX), .topY(topY),
    .visible(visible), .exploding(exploding), .ready(ready), .done(done)
  );
  always #5 CLOCK = ~CLOCK;
  // model: phase 0 idle, 1 flying, 2 exploding, 3 cooling down
  int m_phase = 0, m_x = 0, m_y = 0, m_dir = 0, m_ticks = 0, m_done = 0;
  always @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_phase = 0; m_x = 0; m_y = 0; m_dir = 0; m_ticks = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_phase == 0) begin
        if (fire) begin
          m_phase = 1; m_dir = dir;
          m_x = launch_x > 88 ? 88 : int'(launch_x);
          m_y = launch_y > 56 ? 56 : int'(launch_y);
        end
      end else if (m_phase == 1) begin
        if (hit) begin
          m_phase = 2; m_done = 1; m_ticks = 0;
        end else if (move_tick) begin
          int nx;
          nx = m_dir ? m_x + 2 : m_x - 2;
          if (nx < 0 || nx > 88) begin
            m_phase = 3; m_done = 1; m_ticks = 0;
          end else m_x = nx;
        end
      end else if (move_tick) begin
        m_ticks++;
        if (m_phase == 2 && m_ticks == 4) begin m_phase = 3; m_ticks = 0; end
        else if (m_phase == 3 && m_ticks == 8) m_phase = 0;
      end
    end
  end
  always @(negedge CLOCK) begin
    checks++;
    if (leftX !== 7'(m_x) || topY !== 6'(m_y) || visible !== (m_phase == 1 || m_phase == 2) ||
        exploding !== (m_phase == 2) || ready !== (m_phase == 0) || done !== (m_done == 1)) begin
      errors++;
      $display("FAIL model t=%0t got x=%0d y=%0d vis=%b exp=%b rdy=%b done=%b want x=%0d y=%0d phase=%0d done=%0d",
               $time, leftX, topY, visible, exploding, ready, done, m_x, m_y, m_phase, m_done);
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin @(posedge CLOCK); #1; end
  endtask
  task automatic ticks(input int n);
    repeat (n) begin move_tick = 1; cyc(1); move_tick = 0; cyc(2); end
  endtask
  task automatic launch(input int x, input int y, input logic d);
    launch_x = 7'(x); launch_y = 6'(y); dir = d; fire = 1; cyc(1); fire = 0; cyc(1);
  endtask
  initial begin
    cyc(2);
    chk("rst_ready", ready, 1); chk("rst_x", leftX, 0); chk("rst_vis", visible, 0);
    RESET_N = 1; cyc(1);
    launch(10, 20, 1);
    chk("l1_x", leftX, 10); chk("l1_y", topY, 20); chk("l1_vis", visible, 1);
    ticks(3); chk("l1_x3", leftX, 16);
    RESET_N = 0; #1;
    chk("midrst_x", leftX, 0); chk("midrst_vis", visible, 0);
    chk("midrst_ready", ready, 1); chk("midrst_done", done, 0);
    cyc(2); RESET_N = 1; cyc(1);
    launch(84, 5, 1);
    ticks(1); chk("r_x1", leftX, 86);
    ticks(1); chk("r_x2", leftX, 88);
    move_tick = 1; cyc(1); move_tick = 0;
    chk("r_done", done, 1); chk("r_vis", visible, 0); chk("r_ready", ready, 0);
    cyc(2); ticks(7); chk("r_cd7", ready, 0);
    ticks(1); chk("r_cd8", ready, 1);
    launch(120, 60, 0);
    chk("c_x", leftX, 88); chk("c_y", topY, 56);
    ticks(44); chk("c_x44", leftX, 0);
    move_tick = 1; cyc(1); move_tick = 0;
    chk("c_done", done, 1); chk("c_vis", visible, 0); chk("c_x_nowrap", leftX, 0);
    cyc(2); ticks(8); chk("c_ready", ready, 1);
    launch(88, 10, 1);
    hit = 1; move_tick = 1; cyc(1); hit = 0; move_tick = 0;
    chk("h_exp", exploding, 1); chk("h_x", leftX, 88); chk("h_done", done, 1);
    cyc(2); hit = 1; ticks(3); hit = 0;
    chk("h_exp3", exploding, 1); chk("h_done_once", done, 0);
    ticks(1); chk("h_exp4", exploding, 0); chk("h_vis4", visible, 0); chk("h_rdy4", ready, 0);
    ticks(8); chk("h_idle", ready, 1);
    launch_x = 40; launch_y = 30; dir = 0; fire = 1; cyc(1);
    chk("f_x", leftX, 40);
    ticks(2); chk("f_x2", leftX, 36); chk("f_noref", visible, 1);
    hit = 1; cyc(1); hit = 0; cyc(1);
    ticks(4); launch_x = 50; ticks(7);
    chk("f_cd_ready", ready, 0);
    move_tick = 1; cyc(1); move_tick = 0;
    chk("f_idle", ready, 1);
    cyc(1); fire = 0;
    chk("f_relaunch_x", leftX, 50); chk("f_relaunch_vis", visible, 1);
    hit = 1; cyc(1); hit = 0; cyc(1); ticks(12);
    chk("s_idle", ready, 1);
    launch_x = 30; launch_y = 0; dir = 1; fire = 1; move_tick = 1; cyc(1);
    fire = 0; move_tick = 0; cyc(1);
    chk("s_x", leftX, 30); chk("s_y", topY, 0);
    ticks(1); chk("s_x1", leftX, 32);
    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
